dm_ext: RTL and testbench

Parametrised multi-cycle data memory for the pipelined MIPS core. It replaces the single-cycle word-only data memory. It adds byte and halfword loads and stores, sign or zero extension, and a configurable wait-state latency behind a Req/Ready handshake. It also flags misaligned and out-of-range accesses. It sits in the MEM stage, and the pipeline stalls while a request is outstanding.

---
 rtl/dm_ext.sv | 169 ++++++++++++++++
 tb/tb_dm_ext.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_ext.sv
// dm_ext: multi-cycle byte/half/word data memory behind a Req/Ready handshake; DM_TRACE_EN adds a store trace.
// States: IDLE waits for Req, WAIT counts wait states down, DONE drives the one-cycle Ready pulse.
module dm_ext #(
  parameter int          ADDR_WIDTH  = 10,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Req,
  input  logic        We,
  input  logic [1:0]  Size,
  input  logic        Signed,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  input  logic [31:0] PC,
  output logic        Ready,
  output logic [31:0] ReadData,
  output logic        AddrErr
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t                r_state, w_next;
  logic [3:0]            r_cnt;
  logic                  r_we, r_signed, r_err;
  logic [1:0]            r_size;
  logic [31:0]           r_addr, r_wdata, r_rdata;
  logic [31:0]           r_mem [DEPTH];

  logic                  w_idle, w_accept, w_commit, w_err;
  logic                  w_cur_we, w_cur_signed;
  logic [1:0]            w_cur_size;
  logic [31:0]           w_cur_addr, w_cur_wdata, w_off;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic [31:0]           w_word, w_lanes, w_merged, w_load;
  logic [3:0]            w_be;
  logic [7:0]            w_bsel;
  logic [15:0]           w_hsel;
  logic                  w_unused_off;

  // In IDLE the live inputs decide the access, so WAIT_CYCLES=0 can commit on the accept edge.
  assign w_idle       = (r_state == S_IDLE);
  assign w_accept     = w_idle && Req;
  assign w_cur_we     = w_idle ? We        : r_we;
  assign w_cur_signed = w_idle ? Signed    : r_signed;
  assign w_cur_size   = w_idle ? Size      : r_size;
  assign w_cur_addr   = w_idle ? Addr      : r_addr;
  assign w_cur_wdata  = w_idle ? WriteData : r_wdata;

  assign w_off        = w_cur_addr - BASE_ADDR;
  assign w_idx        = w_off[ADDR_WIDTH+1:2];
  assign w_unused_off = ^w_off[1:0];
  assign w_err        = (w_cur_size == 2'b11) ||
                        (w_cur_size == 2'b01 && w_cur_addr[0]) ||
                        (w_cur_size == 2'b10 && w_cur_addr[1:0] != 2'b00) ||
                        (w_off[31:ADDR_WIDTH+2] != '0);

  // Errored requests never enter WAIT, so a WAIT commit is always a clean access.
  assign w_commit = (w_accept && !w_err && WAIT_CYCLES == 0) ||
                    (r_state == S_WAIT && r_cnt == 4'd1);

  assign w_word = r_mem[w_idx];

  always_comb begin
    w_be    = 4'b1111;
    w_lanes = w_cur_wdata;
    case (w_cur_size)
      2'b00: begin
        w_be    = 4'b0001 << w_cur_addr[1:0];
        w_lanes = {4{w_cur_wdata[7:0]}};
      end
      2'b01: begin
        w_be    = w_cur_addr[1] ? 4'b1100 : 4'b0011;
        w_lanes = {2{w_cur_wdata[15:0]}};
      end
      default: ;
    endcase
    for (int i = 0; i < 4; i++)
      w_merged[8*i +: 8] = w_be[i] ? w_lanes[8*i +: 8] : w_word[8*i +: 8];
  end

  always_comb begin
    w_bsel = w_word[{w_cur_addr[1:0], 3'b000} +: 8];
    w_hsel = w_cur_addr[1] ? w_word[31:16] : w_word[15:0];
    case (w_cur_size)
      2'b00:   w_load = {{24{w_cur_signed & w_bsel[7]}}, w_bsel};
      2'b01:   w_load = {{16{w_cur_signed & w_hsel[15]}}, w_hsel};
      default: w_load = w_word;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (Req) w_next = (w_err || WAIT_CYCLES == 0) ? S_DONE : S_WAIT;
      S_WAIT:  if (r_cnt == 4'd1) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    Ready   = (r_state == S_DONE);
    AddrErr = (r_state == S_DONE) && r_err;
  end

  assign ReadData = r_rdata;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_cnt    <= '0;
      r_we     <= 1'b0;
      r_signed <= 1'b0;
      r_err    <= 1'b0;
      r_size   <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_accept) begin
        r_we     <= We;
        r_signed <= Signed;
        r_size   <= Size;
        r_addr   <= Addr;
        r_wdata  <= WriteData;
        r_err    <= w_err;
        r_cnt    <= 4'(WAIT_CYCLES);
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_commit) begin
        if (w_cur_we) begin
          r_mem[w_idx] <= w_merged;
          r_rdata      <= '0;
        end else begin
          r_rdata <= w_load;
        end
      end
    end
  end

`ifdef DM_TRACE_EN
  logic [31:0] r_pc, w_cur_pc;

  always_ff @(posedge Clk) begin
    if (Rst)           r_pc <= '0;
    else if (w_accept) r_pc <= PC;
  end

  assign w_cur_pc = w_idle ? PC : r_pc;

  always_ff @(posedge Clk) begin
    if (!Rst && w_commit && w_cur_we)
      $display("@%h: *%h <= %h", w_cur_pc, {w_cur_addr[31:2], 2'b00}, w_merged);
  end
`else
  logic w_unused_pc;
  assign w_unused_pc = ^PC;
`endif

endmodule

// File: tb/tb_dm_ext.sv
// Randomised scoreboard bench for dm_ext: a byte-array reference model predicts every response.
module tb_dm_ext;
  localparam int          AW     = 6;
  localparam int          WC     = 2;
  localparam logic [31:0] BASE   = 32'h0000_0100;
  localparam int          NBYTES = 4 << AW;

  logic        Clk = 1'b0;
  logic        Rst, Req, We, Signed;
  logic [1:0]  Size;
  logic [31:0] Addr, WriteData, PC;
  logic        Ready, AddrErr;
  logic [31:0] ReadData;
  logic        Rst0, Req0, Ready0, AddrErr0;
  logic [31:0] ReadData0;

  always #5 Clk = ~Clk;

  dm_ext #(.ADDR_WIDTH(AW), .WAIT_CYCLES(WC), .BASE_ADDR(BASE)) u_dut (
    .Clk(Clk), .Rst(Rst), .Req(Req), .We(We), .Size(Size), .Signed(Signed),
    .Addr(Addr), .WriteData(WriteData), .PC(PC),
    .Ready(Ready), .ReadData(ReadData), .AddrErr(AddrErr)
  );

  dm_ext #(.ADDR_WIDTH(AW), .WAIT_CYCLES(0), .BASE_ADDR(BASE)) u_dut0 (
    .Clk(Clk), .Rst(Rst0), .Req(Req0), .We(We), .Size(Size), .Signed(Signed),
    .Addr(Addr), .WriteData(WriteData), .PC(PC),
    .Ready(Ready0), .ReadData(ReadData0), .AddrErr(AddrErr0)
  );

  typedef struct {
    int unsigned cyc;
    logic        err;
    logic [31:0] rd;
    logic [31:0] addr;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mx;
  int unsigned cyc = 0;
  int          tests = 0;
  int          fails = 0;
  bit          after_done = 0;

  logic [7:0]  mb [NBYTES];
  logic [31:0] last_rd;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic finish_now();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  endtask

  initial begin
    #1_000_000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    finish_now();
  end

  function automatic logic model_err(input logic [1:0] sz, input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00) ||
           (off >= 32'(NBYTES));
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NBYTES; i++) mb[i] = 8'h00;
    last_rd = 32'h0;
  endtask

  task automatic model_access(input logic we_i, input logic [1:0] sz, input logic sg,
                              input logic [31:0] a, input logic [31:0] wd,
                              output logic err, output logic [31:0] rd);
    int     off, n;
    longint v;
    err = model_err(sz, a);
    if (!err) begin
      off = int'(a - BASE);
      n   = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
      if (we_i) begin
        for (int i = 0; i < n; i++) mb[off + i] = wd[8*i +: 8];
        last_rd = 32'h0;
      end else begin
        v = 0;
        for (int i = 0; i < n; i++) v += longint'(mb[off + i]) << (8 * i);
        if (sg && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
        last_rd = v[31:0];
      end
    end
    rd = last_rd;
  endtask

  task automatic drive(input logic rq, input logic we_i, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd);
    Req = rq; We = we_i; Size = sz; Signed = sg; Addr = a; WriteData = wd; PC = $urandom;
  endtask

  task automatic junk(input logic rq);
    drive(rq, 1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom);
  endtask

  // Called at a falling edge with the DUT idle (or in its DONE cycle when after_done is set).
  task automatic issue(input logic we_i, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd, input bit hold, input int gap);
    exp_t        x;
    logic        e;
    logic [31:0] r;
    int          n;
    if (after_done) begin
      if (hold) drive(1'b1, we_i, sz, sg, a, wd);
      else      junk(1'($urandom));
      @(negedge Clk);
    end
    for (int g = 0; g < gap && !hold; g++) begin
      junk(1'b0);
      @(negedge Clk);
    end
    drive(1'b1, we_i, sz, sg, a, wd);
    model_access(we_i, sz, sg, a, wd, e, r);
    x.err  = e;
    x.rd   = r;
    x.addr = a;
    x.cyc  = cyc + 1 + (e ? 0 : WC);
    exp_q.push_back(x);
    @(negedge Clk);
    n = 0;
    while (!Ready && n < 40) begin
      junk(hold ? 1'b1 : 1'($urandom));
      @(negedge Clk);
      n++;
    end
    if (!Ready) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout addr=%h: Ready=0 after %0d cycles, want 1", a, n);
      finish_now();
    end
    after_done = 1;
  endtask

  always @(negedge Clk) begin
    if (!Rst) begin
      tests++;
      if (Ready) begin
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL spurious_ready: Ready=1 with no outstanding request, want 0");
        end else begin
          mx = exp_q.pop_front();
          if (cyc != mx.cyc || AddrErr !== mx.err || ReadData !== mx.rd) begin
            fails++;
            $display("FAIL response addr=%h: got cyc=%0d err=%b rd=%h, want cyc=%0d err=%b rd=%h",
                     mx.addr, cyc, AddrErr, ReadData, mx.cyc, mx.err, mx.rd);
          end
        end
      end else if (AddrErr !== 1'b0) begin
        fails++;
        $display("FAIL addrerr_unqualified: AddrErr=%b while Ready=0, want 0", AddrErr);
      end
    end
  end

  task automatic do0(input logic we_i, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                     input logic [31:0] wd, input logic x_err, input logic [31:0] x_rd,
                     input bit rst_in_done);
    drive(1'b0, we_i, sz, sg, a, wd);
    Req0 = 1'b1;
    @(negedge Clk);
    Req0 = 1'b0;
    tests++;
    if (Ready0 !== 1'b1 || AddrErr0 !== x_err || ReadData0 !== x_rd) begin
      fails++;
      $display("FAIL w0_access addr=%h: got ready=%b err=%b rd=%h, want ready=1 err=%b rd=%h",
               a, Ready0, AddrErr0, ReadData0, x_err, x_rd);
    end
    if (rst_in_done) Rst0 = 1'b1;
    @(negedge Clk);
    Rst0 = 1'b0;
    tests++;
    if (Ready0 !== 1'b0) begin
      fails++;
      $display("FAIL w0_pulse addr=%h: Ready=%b one cycle later, want 0", a, Ready0);
    end
  endtask

  initial begin
    logic [1:0]  sz;
    logic [31:0] a;
    int          k, off;

    Rst = 1'b1; Rst0 = 1'b1; Req0 = 1'b0;
    junk(1'b0);
    model_clear();
    repeat (3) @(negedge Clk);
    tests += 2;
    if (Ready !== 1'b0 || AddrErr !== 1'b0 || ReadData !== 32'h0) begin
      fails++;
      $display("FAIL reset_state: got ready=%b err=%b rd=%h, want 0 0 00000000", Ready, AddrErr, ReadData);
    end
    if (Ready0 !== 1'b0 || AddrErr0 !== 1'b0 || ReadData0 !== 32'h0) begin
      fails++;
      $display("FAIL reset_state_w0: got ready=%b err=%b rd=%h, want 0 0 00000000", Ready0, AddrErr0, ReadData0);
    end
    Rst = 1'b0; Rst0 = 1'b0;
    @(negedge Clk);

    issue(1'b0, 2'b10, 1'b0, BASE + 32'h00, 32'h0, 0, 0);
    issue(1'b1, 2'b10, 1'b0, BASE + 32'h10, 32'h8000_00FF, 0, 0);
    issue(1'b0, 2'b00, 1'b1, BASE + 32'h13, 32'h0, 0, 1);
    issue(1'b0, 2'b00, 1'b0, BASE + 32'h10, 32'h0, 0, 0);
    issue(1'b0, 2'b01, 1'b1, BASE + 32'h12, 32'h0, 0, 0);
    issue(1'b1, 2'b10, 1'b0, BASE + 32'h20, 32'h1122_3344, 1, 0);
    issue(1'b1, 2'b00, 1'b0, BASE + 32'h21, 32'h0000_00AA, 1, 0);
    issue(1'b1, 2'b01, 1'b0, BASE + 32'h22, 32'h0000_BEEF, 1, 0);
    issue(1'b0, 2'b10, 1'b0, BASE + 32'h20, 32'h0, 1, 0);
    issue(1'b1, 2'b01, 1'b0, BASE + 32'h31, 32'h0000_5A5A, 0, 0);
    issue(1'b0, 2'b10, 1'b0, BASE + 32'h22, 32'h0, 0, 0);
    issue(1'b1, 2'b11, 1'b0, BASE + 32'h30, 32'hFFFF_FFFF, 0, 0);
    issue(1'b1, 2'b10, 1'b0, BASE + 32'(NBYTES), 32'h1234_5678, 0, 0);
    issue(1'b0, 2'b10, 1'b0, BASE - 32'h4, 32'h0, 0, 0);
    issue(1'b0, 2'b10, 1'b0, BASE + 32'h30, 32'h0, 0, 0);

    for (int t = 0; t < 300; t++) begin
      k   = $urandom_range(0, 11);
      sz  = (k == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      off = $urandom_range(0, NBYTES - 1);
      if (sz == 2'b01) off = off & ~1;
      if (sz == 2'b10) off = off & ~3;
      if (k == 1) off = off | 1;
      if (k == 2)      a = BASE + 32'(NBYTES) + 32'($urandom_range(0, 1000));
      else if (k == 3) a = BASE - 32'($urandom_range(1, 64));
      else             a = BASE + 32'(off);
      issue(1'($urandom), sz, 1'($urandom), a, $urandom, bit'($urandom_range(0, 1)),
            $urandom_range(0, 2));
    end

    junk(1'b0);
    @(negedge Clk);
    drive(1'b1, 1'b1, 2'b10, 1'b0, BASE + 32'h40, 32'hCAFE_F00D);
    @(negedge Clk);
    junk(1'b0);
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    tests++;
    if (Ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_abort: Ready=%b on aborted commit edge, want 0", Ready);
    end
    Rst = 1'b0;
    model_clear();
    after_done = 0;
    @(negedge Clk);
    issue(1'b0, 2'b10, 1'b0, BASE + 32'h40, 32'h0, 0, 0);
    issue(1'b0, 2'b01, 1'b1, BASE + 32'h22, 32'h0, 0, 0);

    junk(1'b0);
    @(negedge Clk);
    do0(1'b1, 2'b10, 1'b0, BASE + 32'h44, 32'h8765_4321, 1'b0, 32'h0000_0000, 0);
    do0(1'b0, 2'b01, 1'b1, BASE + 32'h46, 32'h0,         1'b0, 32'hFFFF_8765, 0);
    do0(1'b0, 2'b00, 1'b0, BASE + 32'h44, 32'h0,         1'b0, 32'h0000_0021, 0);
    do0(1'b0, 2'b10, 1'b0, BASE + 32'h41, 32'h0,         1'b1, 32'h0000_0021, 0);
    do0(1'b1, 2'b10, 1'b0, BASE + 32'h40, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000, 1);
    do0(1'b0, 2'b10, 1'b0, BASE + 32'h40, 32'h0,         1'b0, 32'h0000_0000, 0);
    do0(1'b0, 2'b10, 1'b0, BASE + 32'h44, 32'h0,         1'b0, 32'h0000_0000, 0);
    do0(1'b0, 2'b00, 1'b0, BASE + 32'(NBYTES), 32'h0,    1'b1, 32'h0000_0000, 0);

    repeat (3) @(negedge Clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d responses outstanding, want 0", exp_q.size());
    end
    finish_now();
  end
endmodule
